pwm_core: RTL and testbench
===========================

# pwm_core

Counter/compare engine of the PWM peripheral, directly downstream of the AXI4-Lite slave register bank (slv_reg0..slv_reg3). It consumes the four software-written registers, shadows them at period boundaries for glitch-free updates, and drives the PWM pin, a period-end strobe and a sticky interrupt. The register bank reads back `cnt_o` and `irq_o` and issues `irq_clr_i`.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: width of register inputs.
- `C_PWM_WIDTH`, 16: counter, period, duty and prescale width; low bits of each register are used, upper bits are ignored.
- `ACLK` in 1: the only clock; all logic is rising-edge.
- `ARESET` in 1: synchronous, active-high reset.
- `ctrl_i` in 32: slv_reg0 (offset 0x0).
  - bit0 EN.
  - bit1 POL: 1 = active-low output.
  - bit2 IRQ_EN.
  - bit3 ONESHOT.
- `period_i` in 32: slv_reg1 (0x4); the period is PERIOD+1 ticks.
- `duty_i` in 32: slv_reg2 (0x8); active ticks per period.
- `prescale_i` in 32: slv_reg3 (0xC); one tick every PRESCALE+1 ACLK cycles.
- `irq_clr_i` in 1: one-cycle clear pulse for the sticky interrupt.
- `pwm_o` out 1: PWM output, registered.
- `period_end_o` out 1: one-cycle strobe.
- `irq_o` out 1: sticky interrupt.
- `cnt_o` out C_PWM_WIDTH: current period counter.
- `busy_o` out 1: high in RUN.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `pre_cnt` = 0 and `cnt` = 0.
  - `pwm_o` = POL, i.e. the inactive level.
  - If EN = 1: load the shadows `per_sh`, `duty_sh` and `pre_sh` from the inputs, then go to RUN.
- **RUN:**
  - `pre_cnt` increments. When `pre_cnt` == `pre_sh`, a tick is generated and `pre_cnt` returns to 0.
  - On each tick:
    - If `cnt` == `per_sh`: `cnt` returns to 0, `period_end_o` pulses, and all shadows reload from the inputs.
    - Otherwise: `cnt` increments.
  - Output: `pwm_o` <= (`cnt` < `duty_sh`) XOR POL. This is an unsigned, C_PWM_WIDTH-bit compare.
  - Duty corner cases:
    - DUTY = 0 gives 0 % duty.
    - DUTY > PERIOD gives 100 % duty.
    - PERIOD = 0 gives a 1-tick period.
  - If ONESHOT = 1 at the wrap: go to DONE instead of starting a new period. The `period_end_o` pulse still occurs.
- **DONE:** output inactive and counters held at 0. Return to IDLE when EN = 0.
- **EN = 0 in RUN:** go to IDLE on the next edge, abandoning the period with no `period_end_o`.
- **Register writes mid-period:** no effect until the next wrap.
- **POL:** applied live, not shadowed.
- **irq_o:**
  - Set on `period_end_o` when IRQ_EN = 1.
  - Cleared by `irq_clr_i`.
  - If set and clear occur in the same cycle, set wins.
  - Clearing IRQ_EN does not clear `irq_o`.

## Timing
- **Reset values:** all outputs 0; state IDLE; all counters and shadows 0.
- **Start-up:**
  - EN is sampled high in IDLE at edge N.
  - State is RUN with `cnt` = 0 after edge N.
  - `pwm_o` reflects `cnt` = 0 after edge N+1.
- **Latency:** one cycle from counter to pin.
- **period_end_o:** high for exactly one cycle, concurrent with `cnt` showing 0 after the wrap.
- **Period length:** (PERIOD+1)·(PRESCALE+1) ACLK cycles.
- **ARESET mid-operation:** returns to the reset values at the next edge, regardless of EN.

## Configuration
- Macro: `PWM_CORE_IRQ_EN`.
- **Defined:** `irq_o`, `irq_clr_i` and the IRQ_EN bit behave as described above.
- **Undefined:** the sticky flag is removed; `irq_o` is tied to 0; `irq_clr_i` and ctrl bit2 are ignored.
- **Unaffected:** `period_end_o` is present in both cases.

## Structure
- **Package `pwm_core_pkg`:**
  - Register offsets 0x0/0x4/0x8/0xC.
  - CTRL bit indices EN/POL/IRQ_EN/ONESHOT.
  - State enum `pwm_state_t` {IDLE, RUN, DONE}.
- **Sub-module `pwm_prescaler`:**
  - Inputs: enable, load, `pre_sh`.
  - Output: one-cycle `tick`.
  - Owns `pre_cnt`.

## Test plan
- **Basic waveform:** PRESCALE=0, PERIOD=3, DUTY=2, EN=1 → `pwm_o` pattern 1,1,0,0 repeating; `period_end_o` every 4 cycles; first high 2 cycles after EN is sampled.
- **Duty extremes and polarity:**
  - DUTY=0 → `pwm_o` always 0.
  - DUTY=5 with PERIOD=3 → always 1.
  - Set POL=1 → waveform inverted on the next cycle.
- **Prescaler and shadowing:**
  - PRESCALE=2, PERIOD=1, DUTY=1 → 3 cycles high, 3 cycles low.
  - Write DUTY=0 mid-period → change takes effect only after the next `period_end_o`.
- **One-shot:**
  - ONESHOT=1, PERIOD=4, DUTY=2 → single pulse of 2 ticks; one `period_end_o`; `busy_o` falls; output stays inactive.
  - EN=0 then EN=1 → a new pulse.
- **Interrupt (`PWM_CORE_IRQ_EN` defined):**
  - IRQ_EN=1 → `irq_o` sets at the first `period_end_o`.
  - `irq_clr_i` coincident with a later `period_end_o` → `irq_o` stays 1.
  - Isolated clear → `irq_o` = 0.
- **Aborts:** ARESET or EN=0 mid-period → next cycle `pwm_o`=POL, `cnt_o`=0, no `period_end_o` pulse.

Source files
------------

// File: rtl/pwm_core_pkg.sv
// pwm_core_pkg: shared definitions for the PWM counter/compare engine.
//   - register offsets of the four software registers (CTRL/PERIOD/DUTY/PRESCALE)
//   - CTRL bit positions
//   - main state encoding
package pwm_core_pkg;

  localparam logic [3:0] REG_CTRL_OFFSET     = 4'h0;
  localparam logic [3:0] REG_PERIOD_OFFSET   = 4'h4;
  localparam logic [3:0] REG_DUTY_OFFSET     = 4'h8;
  localparam logic [3:0] REG_PRESCALE_OFFSET = 4'hC;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_POL     = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_ONESHOT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: divides the clock into counter ticks.
//   clk     : clock (rising edge)
//   srst    : synchronous active-high reset
//   enable  : count while high; counter is held at 0 while low
//   load    : restart the divider from 0 (used when a run begins)
//   pre_sh  : shadowed PRESCALE value; one tick every pre_sh+1 cycles
//   tick    : one-cycle strobe, high in the cycle where pre_cnt == pre_sh
module pwm_prescaler
  import pwm_core_pkg::*;
#(
  parameter int C_PWM_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   enable,
  input  logic                   load,
  input  logic [C_PWM_WIDTH-1:0] pre_sh,
  output logic                   tick
);

  logic [C_PWM_WIDTH-1:0] pre_cnt_reg;
  logic [C_PWM_WIDTH-1:0] pre_cnt_next;

  // tick is combinational so the main counter advances on the same edge
  // that wraps the divider.
  always_comb begin
    tick         = enable && (pre_cnt_reg == pre_sh);
    pre_cnt_next = pre_cnt_reg;
    if (load || !enable) begin
      pre_cnt_next = '0;
    end else if (tick) begin
      pre_cnt_next = '0;
    end else begin
      pre_cnt_next = pre_cnt_reg + C_PWM_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// pwm_core: counter/compare engine of the PWM peripheral.
// Consumes the four software registers, shadows PERIOD/DUTY/PRESCALE at
// period boundaries and drives the PWM pin, a period-end strobe and a
// sticky interrupt.
//   ACLK, ARESET  : clock and synchronous active-high reset
//   ctrl_i        : bit0 EN, bit1 POL (1 = active-low), bit2 IRQ_EN, bit3 ONESHOT
//   period_i      : period is PERIOD+1 ticks
//   duty_i        : active ticks per period
//   prescale_i    : one tick every PRESCALE+1 cycles
//   irq_clr_i     : one-cycle clear of the sticky interrupt
//   pwm_o         : registered PWM output
//   period_end_o  : one-cycle strobe at each wrap
//   irq_o         : sticky interrupt
//   cnt_o         : current period counter
//   busy_o        : high while running
// Build option: define PWM_CORE_IRQ_EN to include the sticky interrupt;
// without it irq_o is tied low and irq_clr_i / IRQ_EN are ignored.
module pwm_core
  import pwm_core_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_PWM_WIDTH        = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] period_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] duty_i,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] prescale_i,
  input  logic                          irq_clr_i,
  output logic                          pwm_o,
  output logic                          period_end_o,
  output logic                          irq_o,
  output logic [C_PWM_WIDTH-1:0]        cnt_o,
  output logic                          busy_o
);

  pwm_state_t state_reg, state_next;

  logic [C_PWM_WIDTH-1:0] cnt_reg, cnt_next;
  logic [C_PWM_WIDTH-1:0] per_sh_reg, per_sh_next;
  logic [C_PWM_WIDTH-1:0] duty_sh_reg, duty_sh_next;
  logic [C_PWM_WIDTH-1:0] pre_sh_reg, pre_sh_next;
  logic                   pwm_reg, pwm_next;
  logic                   pe_reg, pe_next;
  logic                   load_sh;
  logic                   tick;

  logic en, pol, oneshot;
  assign en      = ctrl_i[CTRL_EN];
  assign pol     = ctrl_i[CTRL_POL];
  assign oneshot = ctrl_i[CTRL_ONESHOT];

  pwm_prescaler #(
    .C_PWM_WIDTH(C_PWM_WIDTH)
  ) u_prescaler (
    .clk    (ACLK),
    .srst   (ARESET),
    .enable (state_reg == RUN),
    .load   (state_reg == IDLE),
    .pre_sh (pre_sh_reg),
    .tick   (tick)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pwm_next   = pol;
    pe_next    = 1'b0;
    load_sh    = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (en) begin
          load_sh    = 1'b1;
          state_next = RUN;
        end
      end

      RUN: begin
        if (!en) begin
          // Abandon the period: no strobe, output back to inactive level.
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          // POL is live, duty is shadowed.
          pwm_next = (cnt_reg < duty_sh_reg) ^ pol;
          if (tick) begin
            if (cnt_reg == per_sh_reg) begin
              cnt_next = '0;
              pe_next  = 1'b1;
              load_sh  = 1'b1;
              if (oneshot) begin
                state_next = DONE;
              end
            end else begin
              cnt_next = cnt_reg + C_PWM_WIDTH'(1);
            end
          end
        end
      end

      DONE: begin
        cnt_next = '0;
        if (!en) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Shadows only change at run start or at a wrap, so mid-period register
  // writes cannot glitch the waveform.
  assign per_sh_next  = load_sh ? period_i[C_PWM_WIDTH-1:0]   : per_sh_reg;
  assign duty_sh_next = load_sh ? duty_i[C_PWM_WIDTH-1:0]     : duty_sh_reg;
  assign pre_sh_next  = load_sh ? prescale_i[C_PWM_WIDTH-1:0] : pre_sh_reg;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      per_sh_reg  <= '0;
      duty_sh_reg <= '0;
      pre_sh_reg  <= '0;
      pwm_reg     <= 1'b0;
      pe_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      per_sh_reg  <= per_sh_next;
      duty_sh_reg <= duty_sh_next;
      pre_sh_reg  <= pre_sh_next;
      pwm_reg     <= pwm_next;
      pe_reg      <= pe_next;
    end
  end

  assign pwm_o        = pwm_reg;
  assign period_end_o = pe_reg;
  assign cnt_o        = cnt_reg;
  assign busy_o       = (state_reg == RUN);

`ifdef PWM_CORE_IRQ_EN
  logic irq_reg;

  // Set is taken from the strobe itself, so a clear arriving in the same
  // cycle as period_end_o loses to the set.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= (pe_reg & ctrl_i[CTRL_IRQ_EN]) | (irq_reg & ~irq_clr_i);
    end
  end

  assign irq_o = irq_reg;
`else
  assign irq_o = 1'b0;
`endif

  // Upper register bits (and the interrupt inputs when the flag is
  // compiled out) are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ctrl_i, period_i, duty_i, prescale_i, irq_clr_i};

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: directed, table-driven bench for pwm_core plus hand-written
// sequences for one-shot and interrupt behaviour.
module tb_pwm_core;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] ctrl_i, period_i, duty_i, prescale_i;
  logic        irq_clr_i;
  logic        pwm_o, period_end_o, irq_o, busy_o;
  logic [15:0] cnt_o;

  always #5 ACLK = ~ACLK;

  pwm_core #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_PWM_WIDTH(16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .ctrl_i       (ctrl_i),
    .period_i     (period_i),
    .duty_i       (duty_i),
    .prescale_i   (prescale_i),
    .irq_clr_i    (irq_clr_i),
    .pwm_o        (pwm_o),
    .period_end_o (period_end_o),
    .irq_o        (irq_o),
    .cnt_o        (cnt_o),
    .busy_o       (busy_o)
  );

`ifdef PWM_CORE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  typedef struct {
    logic        areset;
    logic [3:0]  ctrl;
    logic [15:0] period;
    logic [15:0] duty;
    logic [15:0] prescale;
    logic        exp_pwm;
    logic        exp_pe;
    logic [15:0] exp_cnt;
    logic        exp_busy;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input int ar, input int ctrl, input int per, input int duty,
                     input int pre, input int pwm, input int pe, input int cnt,
                     input int busy);
    vec_t v;
    v.areset   = 1'(ar);
    v.ctrl     = 4'(ctrl);
    v.period   = 16'(per);
    v.duty     = 16'(duty);
    v.prescale = 16'(pre);
    v.exp_pwm  = 1'(pwm);
    v.exp_pe   = 1'(pe);
    v.exp_cnt  = 16'(cnt);
    v.exp_busy = 1'(busy);
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // One-shot: PERIOD=4, DUTY=2 -> exactly 2 high cycles and one strobe.
  task automatic oneshot_run(input string tag);
    int highs;
    int pes;
    highs = 0;
    pes   = 0;
    period_i = 32'd4; duty_i = 32'd2; prescale_i = 32'd0; ctrl_i = 32'h9;
    step();
    chk({tag, "_start_busy"}, 32'(busy_o), 32'd1);
    chk({tag, "_start_cnt"}, 32'(cnt_o), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      highs += int'(pwm_o);
      pes   += int'(period_end_o);
      if (k == 5) begin
        chk({tag, "_wrap_pe"}, 32'(period_end_o), 32'd1);
        chk({tag, "_wrap_busy"}, 32'(busy_o), 32'd0);
      end
      if (k > 5) begin
        chk($sformatf("%s_done_pwm%0d", tag, k), 32'(pwm_o), 32'd0);
      end
    end
    chk({tag, "_highs"}, 32'(highs), 32'd2);
    chk({tag, "_pes"}, 32'(pes), 32'd1);
    $display("%s oneshot highs=%0d period_ends=%0d busy=%0b", tag, highs, pes, busy_o);
  endtask

  initial begin
    ARESET = 1'b1; ctrl_i = '0; period_i = '0; duty_i = '0; prescale_i = '0;
    irq_clr_i = 1'b0;
    #1;
    step();
    step();
    chk("rst_pwm", 32'(pwm_o), 32'd0);
    chk("rst_pe", 32'(period_end_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    $display("reset pwm=%0b pe=%0b irq=%0b cnt=%0d busy=%0b",
             pwm_o, period_end_o, irq_o, cnt_o, busy_o);

    // ar ctrl per duty pre | pwm pe cnt busy
    // Basic waveform: PERIOD=3 DUTY=2 PRESCALE=0 -> 1,1,0,0
    add(0, 1, 3, 2, 0, 0, 0, 0, 1);
    add(0, 1, 3, 2, 0, 1, 0, 1, 1);
    add(0, 1, 3, 2, 0, 1, 0, 2, 1);
    add(0, 1, 3, 2, 0, 0, 0, 3, 1);
    add(0, 1, 3, 2, 0, 0, 1, 0, 1);
    add(0, 1, 3, 2, 0, 1, 0, 1, 1);
    add(0, 1, 3, 2, 0, 1, 0, 2, 1);
    add(0, 1, 3, 2, 0, 0, 0, 3, 1);
    add(0, 1, 3, 2, 0, 0, 1, 0, 1);
    // POL=1: inverted from the next cycle
    add(0, 3, 3, 2, 0, 0, 0, 1, 1);
    add(0, 3, 3, 2, 0, 0, 0, 2, 1);
    add(0, 3, 3, 2, 0, 1, 0, 3, 1);
    add(0, 3, 3, 2, 0, 1, 1, 0, 1);
    add(0, 1, 3, 2, 0, 1, 0, 1, 1);
    // DUTY=0 written mid-period: old duty until the wrap, then always low
    add(0, 1, 3, 0, 0, 1, 0, 2, 1);
    add(0, 1, 3, 0, 0, 0, 0, 3, 1);
    add(0, 1, 3, 0, 0, 0, 1, 0, 1);
    add(0, 1, 3, 0, 0, 0, 0, 1, 1);
    add(0, 1, 3, 0, 0, 0, 0, 2, 1);
    add(0, 1, 3, 0, 0, 0, 0, 3, 1);
    add(0, 1, 3, 0, 0, 0, 1, 0, 1);
    // DUTY=5 > PERIOD=3: after the next wrap, always high
    add(0, 1, 3, 5, 0, 0, 0, 1, 1);
    add(0, 1, 3, 5, 0, 0, 0, 2, 1);
    add(0, 1, 3, 5, 0, 0, 0, 3, 1);
    add(0, 1, 3, 5, 0, 0, 1, 0, 1);
    add(0, 1, 3, 5, 0, 1, 0, 1, 1);
    add(0, 1, 3, 5, 0, 1, 0, 2, 1);
    add(0, 1, 3, 5, 0, 1, 0, 3, 1);
    add(0, 1, 3, 5, 0, 1, 1, 0, 1);
    add(0, 1, 3, 5, 0, 1, 0, 1, 1);
    // EN=0 mid-period: abort, no strobe
    add(0, 0, 3, 5, 0, 0, 0, 0, 0);
    add(0, 0, 3, 5, 0, 0, 0, 0, 0);
    // PRESCALE=2 PERIOD=1 DUTY=1 -> 3 high, 3 low
    add(0, 1, 1, 1, 2, 0, 0, 0, 1);
    add(0, 1, 1, 1, 2, 1, 0, 0, 1);
    add(0, 1, 1, 1, 2, 1, 0, 0, 1);
    add(0, 1, 1, 1, 2, 1, 0, 1, 1);
    add(0, 1, 1, 1, 2, 0, 0, 1, 1);
    add(0, 1, 1, 1, 2, 0, 0, 1, 1);
    add(0, 1, 1, 1, 2, 0, 1, 0, 1);
    add(0, 1, 1, 1, 2, 1, 0, 0, 1);
    add(0, 1, 1, 1, 2, 1, 0, 0, 1);
    add(0, 1, 1, 1, 2, 1, 0, 1, 1);
    add(0, 1, 1, 1, 2, 0, 0, 1, 1);
    // ARESET mid-run with EN still high
    add(1, 1, 1, 1, 2, 0, 0, 0, 0);
    add(0, 0, 1, 1, 2, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      ARESET     = vq[i].areset;
      ctrl_i     = 32'(vq[i].ctrl);
      period_i   = 32'(vq[i].period);
      duty_i     = 32'(vq[i].duty);
      prescale_i = 32'(vq[i].prescale);
      step();
      $display("vec %0d pwm=%0b pe=%0b cnt=%0d busy=%0b",
               i, pwm_o, period_end_o, cnt_o, busy_o);
      chk($sformatf("vec%0d_pwm", i), 32'(pwm_o), 32'(vq[i].exp_pwm));
      chk($sformatf("vec%0d_pe", i), 32'(period_end_o), 32'(vq[i].exp_pe));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_o), 32'(vq[i].exp_cnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vq[i].exp_busy));
    end

    // One-shot, then EN low and a second pulse.
    oneshot_run("os1");
    ctrl_i = 32'h0;
    step();
    chk("os_idle_busy", 32'(busy_o), 32'd0);
    oneshot_run("os2");
    ctrl_i = 32'h0;
    step();
    step();

    // Interrupt: PERIOD=1, DUTY=1, EN|IRQ_EN.
    period_i = 32'd1; duty_i = 32'd1; prescale_i = 32'd0; ctrl_i = 32'h5;
    step();                                    // E0: RUN, cnt 0
    step();                                    // E1: cnt 1
    step();                                    // E2: wrap
    chk("irq_e2_pe", 32'(period_end_o), 32'd1);
    chk("irq_e2_irq", 32'(irq_o), 32'd0);
    step();                                    // E3: flag sets
    chk("irq_set", 32'(irq_o), 32'(IRQ_ON));
    $display("irq set irq=%0b", irq_o);
    step();                                    // E4: second strobe
    chk("irq_e4_pe", 32'(period_end_o), 32'd1);
    irq_clr_i = 1'b1;                          // clear coincident with strobe
    step();
    chk("irq_set_wins", 32'(irq_o), 32'(IRQ_ON));
    $display("irq clear-with-set irq=%0b", irq_o);
    step();                                    // E6: isolated clear (pe low at E5)
    irq_clr_i = 1'b0;
    chk("irq_cleared", 32'(irq_o), 32'd0);
    $display("irq isolated-clear irq=%0b", irq_o);
    step();                                    // E7: set again from E6 strobe
    chk("irq_reset_again", 32'(irq_o), 32'(IRQ_ON));
    ctrl_i = 32'h1;                            // drop IRQ_EN
    step();
    step();                                    // E9: strobe at E8 with IRQ_EN=0
    chk("irq_hold_no_en", 32'(irq_o), 32'(IRQ_ON));
    $display("irq after IRQ_EN drop irq=%0b", irq_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
